// File: rtl/alarm_setter.sv
// Alarm-time set/edit FSM with user enable and snooze offset control.
// Drives the target time and enable into the alarm comparator.
module alarm_setter #(
  parameter int unsigned data_width   = 18,
  parameter int unsigned default_hour = 7,
  parameter int unsigned default_min  = 0,
  parameter int unsigned snooze_min   = 5,
  parameter int unsigned max_snooze   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_mode,
  input  logic                  key_inc,
  input  logic                  key_enable,
  input  logic                  key_snooze,
  input  logic                  alarm_ringing,
  output logic [data_width-1:0] alarm_data,
  output logic                  alarm_enable,
  output logic [1:0]            edit_field,
  output logic [1:0]            snooze_count
);

  localparam int unsigned FW = 6;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_SEC  = 2'd3;

  logic [1:0]    state, next_state;
  logic [FW-1:0] set_hour, set_min, set_sec;
  logic [FW-1:0] next_set_hour, next_set_min, next_set_sec;
  logic [FW-1:0] off_hour, off_min, next_off_hour, next_off_min;
  logic [1:0]    next_snooze_count;
  logic          enable_bit, next_enable_bit;
  logic          snooze_kill, next_snooze_kill;
  logic          snooze_ok;
  logic [6:0]    snz_min_sum;
  logic [6:0]    sum_min;
  logic [FW-1:0] sum_hour;
  logic [FW-1:0] tgt_hour, tgt_min;

  // Next-state and key handling; keys are prioritised enable > mode > inc > snooze.
  always_comb begin
    next_state        = state;
    next_set_hour     = set_hour;
    next_set_min      = set_min;
    next_set_sec      = set_sec;
    next_off_hour     = off_hour;
    next_off_min      = off_min;
    next_snooze_count = snooze_count;
    next_enable_bit   = enable_bit;
    next_snooze_kill  = 1'b0;

    snooze_ok   = (state == IDLE) && alarm_ringing && enable_bit &&
                  (snooze_count < 2'(max_snooze));
    snz_min_sum = 7'(off_min) + 7'(snooze_min);

    if (key_enable) begin
      next_enable_bit   = ~enable_bit;
      next_off_hour     = '0;
      next_off_min      = '0;
      next_snooze_count = '0;
    end else if (key_mode) begin
      case (state)
        IDLE: begin
          next_state        = SET_HOUR;
          next_off_hour     = '0;
          next_off_min      = '0;
          next_snooze_count = '0;
        end
        SET_HOUR: next_state = SET_MIN;
        SET_MIN:  next_state = SET_SEC;
        default:  next_state = IDLE;
      endcase
    end else if (key_inc) begin
      case (state)
        SET_HOUR: next_set_hour = (set_hour == 6'd23) ? '0 : set_hour + 6'd1;
        SET_MIN:  next_set_min  = (set_min  == 6'd59) ? '0 : set_min  + 6'd1;
        SET_SEC:  next_set_sec  = (set_sec  == 6'd59) ? '0 : set_sec  + 6'd1;
        default:  ;
      endcase
    end else if (key_snooze && snooze_ok) begin
      // Offset is itself a time value that wraps at 24 h.
      if (snz_min_sum >= 7'd60) begin
        next_off_min  = 6'(snz_min_sum - 7'd60);
        next_off_hour = (off_hour == 6'd23) ? '0 : off_hour + 6'd1;
      end else begin
        next_off_min  = 6'(snz_min_sum);
      end
      next_snooze_count = snooze_count + 2'd1;
      next_snooze_kill  = 1'b1;
    end
  end

  // Target time = set register + snooze offset, second field untouched.
  always_comb begin
    sum_min  = 7'(set_min) + 7'(off_min);
    tgt_min  = (sum_min >= 7'd60) ? 6'(sum_min - 7'd60) : 6'(sum_min);
    sum_hour = set_hour + off_hour + ((sum_min >= 7'd60) ? 6'd1 : 6'd0);
    tgt_hour = (sum_hour >= 6'd24) ? sum_hour - 6'd24 : sum_hour;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      set_hour     <= 6'(default_hour);
      set_min      <= 6'(default_min);
      set_sec      <= '0;
      off_hour     <= '0;
      off_min      <= '0;
      snooze_count <= '0;
      enable_bit   <= 1'b0;
      snooze_kill  <= 1'b0;
      alarm_data   <= data_width'({6'(default_hour), 6'(default_min), 6'd0});
    end else begin
      state        <= next_state;
      set_hour     <= next_set_hour;
      set_min      <= next_set_min;
      set_sec      <= next_set_sec;
      off_hour     <= next_off_hour;
      off_min      <= next_off_min;
      snooze_count <= next_snooze_count;
      enable_bit   <= next_enable_bit;
      snooze_kill  <= next_snooze_kill;
      alarm_data   <= data_width'({tgt_hour, tgt_min, set_sec});
    end
  end

  // Pure decodes of registered state.
  assign edit_field   = state;
  assign alarm_enable = enable_bit && (state == IDLE) && !snooze_kill;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed self-checking bench for alarm_setter.
module tb_alarm_setter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_mode = 1'b0, key_inc = 1'b0, key_enable = 1'b0, key_snooze = 1'b0;
  logic        alarm_ringing = 1'b0;
  logic [17:0] alarm_data;
  logic        alarm_enable;
  logic [1:0]  edit_field;
  logic [1:0]  snooze_count;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] K_EN = 4'b1000, K_MODE = 4'b0100, K_INC = 4'b0010, K_SNZ = 4'b0001;

  alarm_setter dut (
    .clock(clock), .reset(reset),
    .key_mode(key_mode), .key_inc(key_inc), .key_enable(key_enable),
    .key_snooze(key_snooze), .alarm_ringing(alarm_ringing),
    .alarm_data(alarm_data), .alarm_enable(alarm_enable),
    .edit_field(edit_field), .snooze_count(snooze_count)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Keys {enable, mode, inc, snooze} held for exactly one rising edge.
  task automatic press(input logic [3:0] k);
    @(negedge clock);
    {key_enable, key_mode, key_inc, key_snooze} = k;
    @(negedge clock);
    {key_enable, key_mode, key_inc, key_snooze} = 4'b0;
  endtask

  task automatic press_n(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    // Reset state
    #12 reset = 1'b1;
    tick();
    check("rst_data", 32'(alarm_data), 32'(hms(7, 0, 0)));
    check("rst_en", 32'(alarm_enable), 32'd0);
    check("rst_field", 32'(edit_field), 32'd0);
    check("rst_cnt", 32'(snooze_count), 32'd0);

    // Edit walk: hour 7 -> 1 via wrap, minute 0 -> 1 via wrap
    press(K_MODE);
    check("field_hour", 32'(edit_field), 32'd1);
    press_n(K_INC, 18);
    check("en_in_edit", 32'(alarm_enable), 32'd0);
    press(K_MODE);
    check("field_min", 32'(edit_field), 32'd2);
    press_n(K_INC, 61);
    press(K_MODE);
    check("field_sec", 32'(edit_field), 32'd3);
    press(K_MODE);
    check("field_idle", 32'(edit_field), 32'd0);
    tick();
    check("edit_data", 32'(alarm_data), 32'(hms(1, 1, 0)));
    check("en_after_edit", 32'(alarm_enable), 32'd0);

    // Set 23:57:00 and enable
    press(K_MODE);
    press_n(K_INC, 22);
    press(K_MODE);
    press_n(K_INC, 56);
    press_n(K_MODE, 2);
    press(K_EN);
    tick();
    check("set_2357", 32'(alarm_data), 32'(hms(23, 57, 0)));
    check("en_on", 32'(alarm_enable), 32'd1);

    // First snooze wraps past midnight
    alarm_ringing = 1'b1;
    press(K_SNZ);
    check("kill_low", 32'(alarm_enable), 32'd0);
    check("cnt1", 32'(snooze_count), 32'd1);
    tick();
    check("kill_one_cycle", 32'(alarm_enable), 32'd1);
    check("snz1_data", 32'(alarm_data), 32'(hms(0, 2, 0)));

    // Snooze without ringing is ignored
    alarm_ringing = 1'b0;
    press(K_SNZ);
    check("noring_en", 32'(alarm_enable), 32'd1);
    check("noring_cnt", 32'(snooze_count), 32'd1);
    tick();
    check("noring_data", 32'(alarm_data), 32'(hms(0, 2, 0)));

    // Snooze up to the limit, then one more is dropped
    alarm_ringing = 1'b1;
    press(K_SNZ);
    press(K_SNZ);
    check("cnt3", 32'(snooze_count), 32'd3);
    tick();
    check("snz3_data", 32'(alarm_data), 32'(hms(0, 12, 0)));
    press(K_SNZ);
    check("snz4_nokill", 32'(alarm_enable), 32'd1);
    check("snz4_cnt", 32'(snooze_count), 32'd3);
    tick();
    check("snz4_data", 32'(alarm_data), 32'(hms(0, 12, 0)));

    // key_enable while snoozed clears offset and count
    press(K_EN);
    check("en_off_silence", 32'(alarm_enable), 32'd0);
    check("en_clr_cnt", 32'(snooze_count), 32'd0);
    tick();
    check("en_clr_data", 32'(alarm_data), 32'(hms(23, 57, 0)));
    press(K_EN);
    press(K_SNZ);
    check("resnz_cnt", 32'(snooze_count), 32'd1);

    // Entering edit clears snooze; snooze in SET_MIN is ignored
    press(K_MODE);
    check("edit_clr_cnt", 32'(snooze_count), 32'd0);
    check("edit_en_low", 32'(alarm_enable), 32'd0);
    press(K_MODE);
    press(K_SNZ);
    check("setmin_field", 32'(edit_field), 32'd2);
    check("setmin_cnt", 32'(snooze_count), 32'd0);
    tick();
    check("setmin_data", 32'(alarm_data), 32'(hms(23, 57, 0)));
    press_n(K_MODE, 2);
    alarm_ringing = 1'b0;
    check("back_idle_en", 32'(alarm_enable), 32'd1);

    // Enable beats inc in SET_HOUR; mode beats inc too
    press(K_MODE);
    press(K_EN | K_INC);
    check("prio_field", 32'(edit_field), 32'd1);
    press(K_MODE | K_INC);
    check("prio_mode", 32'(edit_field), 32'd2);
    press_n(K_MODE, 2);
    tick();
    check("prio_data", 32'(alarm_data), 32'(hms(23, 57, 0)));
    check("prio_en_off", 32'(alarm_enable), 32'd0);

    // Async reset mid-edit
    press(K_MODE);
    press(K_INC);
    #2 reset = 1'b0;
    #1;
    check("async_field", 32'(edit_field), 32'd0);
    check("async_data", 32'(alarm_data), 32'(hms(7, 0, 0)));
    check("async_cnt", 32'(snooze_count), 32'd0);
    #4 reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
